// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner codes, counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and debug ports.
// ARB_RR_EN defined: ties go to the port that is not last_owner; undefined: CPU always wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

`ifdef ARB_RR_EN
  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_owner = OWN_CPU;
    if (cpu_req && dbg_req) begin
      grant_owner = ~last_owner;
    end else if (dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end
`else
  // Fixed priority never looks at the previous winner.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_owner = OWN_CPU;
    if (!cpu_req && dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the single unified memory (CPU port vs debug/loader port).
// Tie-breaking is fixed CPU priority unless ARB_RR_EN is defined (round-robin, resolved in mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic [1:0]        state
);

  // state | meaning
  // IDLE  | wait for a request; latch the winner into mem_* and load the latency counter
  // BUSY  | mem_* held stable; write strobe only in the first cycle; read captured at count 0
  // DONE  | one-cycle ready pulse to the winner; winner recorded as last_owner

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic grant_valid;
  logic grant_owner;

  mem_arb_pick u_pick (
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
          if (grant_owner == OWN_DBG) begin
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            we_d        = dbg_we;
          end else begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            we_d        = cpu_we;
          end
          mem_we_d = (grant_owner == OWN_DBG) ? dbg_we : cpu_we;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_ready = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign dbg_ready = (state_q == ST_DONE) && (owner_q == OWN_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign owner     = owner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model predicts each access and its ready cycle,
// a negedge monitor checks every ready pulse and write strobe against the expectation queues.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic              clk, rst;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic              cpu_ready, dbg_ready, mem_we, owner;
  logic [1:0]        state;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .owner(owner), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
  endtask

  // Memory: untouched words read back a fixed per-address pattern.
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 10'h005) return 32'h8C010014;
    return (32'h9E3779B9 * {22'd0, a}) ^ 32'h5A5A0000;
  endfunction

  logic [DATA_W-1:0] mem_arr [1 << ADDR_W];
  bit                mem_wr  [1 << ADDR_W];
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem_arr[mem_addr] <= mem_wdata;
      mem_wr[mem_addr]  <= 1'b1;
    end
  end
  assign mem_rdata = mem_wr[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr);

  // Reference model: one access at a time, each occupying LAT+2 cycles from its grant.
  typedef struct {
    bit                port;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                at_cyc;
  } exp_t;

  exp_t rq[$];
  exp_t wq[$];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  bit                ref_wr  [1 << ADDR_W];
  int  idle_at = 0;
  bit  m_last = 1'b1;
  bit  pend_valid = 0;
  bit  pend_owner = 0;
  int  pend_done = 0;

  always @(posedge clk) begin
    exp_t e;
    bit win;
    if (!rst) begin
      rq.delete();
      wq.delete();
      idle_at    = cyc + 1;
      m_last     = 1'b1;
      pend_valid = 0;
      started    = 1;
    end else if (started) begin
      if (pend_valid && cyc == pend_done) begin
        m_last     = pend_owner;
        pend_valid = 0;
      end
      if (cyc >= idle_at && (cpu_req || dbg_req)) begin
`ifdef ARB_RR_EN
        win = (cpu_req && dbg_req) ? !m_last : dbg_req;
`else
        win = !cpu_req;
`endif
        e.port   = win;
        e.we     = win ? dbg_we : cpu_we;
        e.addr   = win ? dbg_addr : cpu_addr;
        e.wdata  = win ? dbg_wdata : cpu_wdata;
        e.rdata  = ref_wr[e.addr] ? ref_mem[e.addr] : init_val(e.addr);
        e.at_cyc = cyc + LAT + 1;
        rq.push_back(e);
        if (e.we) begin
          ref_mem[e.addr] = e.wdata;
          ref_wr[e.addr]  = 1'b1;
          e.at_cyc = cyc + 1;
          wq.push_back(e);
        end
        pend_valid = 1;
        pend_owner = win;
        pend_done  = cyc + LAT + 1;
        idle_at    = cyc + LAT + 2;
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: compares whatever the DUT presents against the queued expectations.
  logic [DATA_W-1:0] m_rdata [2];
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (wq.size() > 0 && wq[0].at_cyc == cyc) begin
        e = wq.pop_front();
        chk("mem_we_strobe", mem_we, 1'b1);
        chk("mem_addr_wr", mem_addr, e.addr);
        chk("mem_wdata_wr", mem_wdata, e.wdata);
      end else if (mem_we !== 1'b0) begin
        fail("mem_we_spurious", mem_we, 1'b0);
      end

      if (cpu_ready === 1'b1 || dbg_ready === 1'b1) begin
        chk("ready_exclusive", cpu_ready & dbg_ready, 1'b0);
        if (rq.size() == 0) begin
          fail("ready_unexpected", {cpu_ready, dbg_ready}, 2'b00);
        end else begin
          e = rq.pop_front();
          chk("ready_cycle", cyc, e.at_cyc);
          chk("ready_port", dbg_ready, e.port);
          chk("owner_at_ready", owner, e.port);
          chk("state_at_ready", state, 2'd2);
          chk(e.port ? "dbg_rdata" : "cpu_rdata", e.port ? dbg_rdata : cpu_rdata,
              e.we ? m_rdata[e.port] : e.rdata);
          if (!e.we) m_rdata[e.port] = e.rdata;
        end
      end else if (rq.size() > 0 && rq[0].at_cyc <= cyc) begin
        e = rq.pop_front();
        fail(e.port ? "dbg_ready_missing" : "cpu_ready_missing", 1'b0, 1'b1);
      end
    end
    if (rst === 1'b0) begin
      m_rdata[0] = '0;
      m_rdata[1] = '0;
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return ADDR_W'($urandom_range(0, 7));
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  task automatic new_cpu(input bit rd_only);
    cpu_we    = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    cpu_addr  = rand_addr();
    cpu_wdata = $urandom;
  endtask

  task automatic new_dbg(input bit rd_only);
    dbg_we    = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    dbg_addr  = rand_addr();
    dbg_wdata = $urandom;
  endtask

  // Each port issues n accesses back-to-back, holding its request until it sees ready.
  task automatic run_reqs(input int n_cpu, input int n_dbg, input bit rst_en, input bit rd_only);
    int cl = n_cpu;
    int dl = n_dbg;
    int budget = 200;
    if (cl > 0) begin new_cpu(rd_only); cpu_req = 1'b1; end
    if (dl > 0) begin new_dbg(rd_only); dbg_req = 1'b1; end
    while ((cl > 0 || dl > 0) && budget > 0) begin
      rst = (rst_en && $urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      tick();
      budget--;
      if (cpu_ready === 1'b1 && cl > 0) begin
        cl--;
        if (cl > 0) new_cpu(rd_only); else cpu_req = 1'b0;
      end
      if (dbg_ready === 1'b1 && dl > 0) begin
        dl--;
        if (dl > 0) new_dbg(rd_only); else dbg_req = 1'b0;
      end
    end
    rst = 1'b1;
    if (budget == 0) fail("run_reqs_timeout", cl + dl, 0);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset held two cycles with a CPU request pending
    tick(); tick();
    chk("rst_state", state, 2'd0);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_dbg_ready", dbg_ready, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 10'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_owner", owner, 1'b0);
    rst = 1'b1; cpu_req = 1'b0;
    tick();

    // CPU read of 0x005
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    tick();
    chk("t2_mem_addr_c1", mem_addr, 10'h005);
    chk("t2_state_c1", state, 2'd1);
    tick();
    chk("t2_mem_addr_c2", mem_addr, 10'h005);
    tick();
    chk("t2_cpu_ready_c3", cpu_ready, 1'b1);
    chk("t2_cpu_rdata_c3", cpu_rdata, 32'h8C010014);
    chk("t2_dbg_ready_c3", dbg_ready, 1'b0);
    cpu_req = 1'b0;
    tick();

    // Debug write 0x7 to 0x016
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h016; dbg_wdata = 32'h7;
    tick();
    chk("t3_mem_we_c1", mem_we, 1'b1);
    chk("t3_mem_wdata_c1", mem_wdata, 32'h7);
    tick();
    chk("t3_mem_we_c2", mem_we, 1'b0);
    tick();
    chk("t3_dbg_ready_c3", dbg_ready, 1'b1);
    chk("t3_dbg_rdata_c3", dbg_rdata, 32'h0);
    dbg_req = 1'b0;
    tick();

    // Both ports contending through two accesses
    run_reqs(2, 1, 1'b0, 1'b0);
    tick();

    // Reset during cycle 1 of a CPU read, then a debug read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h009;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_state_after_rst", state, 2'd0);
    rst = 1'b1; cpu_req = 1'b0;
    tick(); tick();
    run_reqs(0, 1, 1'b0, 1'b1);
    tick();

    // CPU request dropped in cycle 1, all-ones address
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '1;
    tick();
    cpu_req = 1'b0;
    tick(); tick();
    chk("t6_cpu_ready_c3", cpu_ready, 1'b1);
    tick(); tick(); tick();
    chk("t6_state_idle", state, 2'd0);

    // Random contention with occasional mid-access resets
    repeat (150) begin
      run_reqs($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (10) tick();
    chk("drain_ready_queue", rq.size(), 0);
    chk("drain_write_queue", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the multi-cycle CPU's single unified memory. It shares the memory between the CPU controller's memory port (instruction fetch and load/store, selected upstream by `iord`) and a debug/loader port. It serialises accesses, holds the memory address and data stable for a fixed read latency, and returns a one-cycle ready pulse to the winning requester. It sits between the CPU datapath's memory interface and the memory instance.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width.
- `DATA_W`, 32: data width.
- `LATENCY`, 2: number of cycles the memory needs to produce `mem_rdata`. Valid range is 1 to 15.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `cpu_req`  in  1  CPU access request.
- `cpu_we`  in  1  CPU write enable.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  CPU read data, registered.
- `cpu_ready`  out  1  CPU completion pulse.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ready`: same as the CPU set, for the debug/loader port.
- `mem_addr`  out  ADDR_W  memory address, registered.
- `mem_wdata`  out  DATA_W  memory write data, registered.
- `mem_we`  out  1  memory write strobe, registered.
- `mem_rdata`  in  DATA_W  memory read data.
- `owner`  out  1  current or last grant: 0 = CPU, 1 = debug.
- `state`  out  2  FSM state, for observation.

## Operation
- Reset (`rst`=0 at an edge) puts every output at 0 and sets `state`=IDLE.
- Reset also sets internal `last_owner` to 1 (debug) and the latency counter to 0.
- FSM states:
  - IDLE (0): if any request is present, pick a winner, latch its `addr`, `we` and `wdata` into the `mem_*` registers, set `owner`, load the counter with LATENCY-1, and go to BUSY. With no request, stay in IDLE with `mem_we`=0.
  - BUSY (1): `mem_addr` and `mem_wdata` are held. `mem_we` equals the latched `we` only in the first BUSY cycle and is 0 afterwards, so each write is a single pulse. The counter decrements each cycle. At counter=0, capture `mem_rdata` into the winner's `rdata` register (reads only) and go to DONE.
  - DONE (2): the winner's `ready`=1 for exactly this cycle, then go to IDLE. Update `last_owner` to the current `owner`.
- Writes never change either `rdata` register.
- Each `rdata` register holds its value until the next completed read on that port.
- Requester rule: hold `req`, `we`, `addr` and `wdata` stable from assertion until `ready` is seen. After `ready`, the requester may keep `req` high for a back-to-back access; it is re-arbitrated in the next IDLE cycle.
- `req` dropped mid-access: the access still completes, `ready` still pulses once, and no new access starts unless `req` is high in IDLE.
- Reset mid-access: the FSM returns to IDLE at the next edge with no `ready` pulse. A write already strobed is not undone.
- Address and data pass through unmodified, including an all-ones address. There is no wrap or arithmetic on them.
- The counter is 4 bits wide.

## Timing
- The request is sampled in IDLE (cycle 0).
- `mem_*` are valid in cycles 1 through LATENCY.
- `ready` and `rdata` are valid in cycle LATENCY+1.
- The next grant can occur no earlier than cycle LATENCY+2.
- Minimum access period is LATENCY+2 cycles. For example, LATENCY=2 gives `ready` in cycle 3 and a 4-cycle period.
- `cpu_ready` and `dbg_ready` are never high in the same cycle.

## Configuration
- `ARB_RR_EN` undefined: fixed priority, CPU wins whenever both requests are present. A CPU that holds `req` continuously starves the debug port; this is accepted behaviour.
- `ARB_RR_EN` defined: round-robin. When both requests are present, grant the port that is not `last_owner`. A lone request always wins.
- Because `last_owner` resets to 1, the first tie after reset goes to the CPU in both modes.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encodings: `ST_IDLE`=2'd0, `ST_BUSY`=2'd1, `ST_DONE`=2'd2;
  - owner encodings: `OWN_CPU`=1'b0, `OWN_DBG`=1'b1.
- One sub-module, `mem_arb_pick`: combinational winner selection.
  - Inputs: `cpu_req`, `dbg_req`, `last_owner`.
  - Outputs: `grant_valid`, `grant_owner`.
  - `ARB_RR_EN` is resolved inside this sub-module.
- The FSM, counter and registers live in `mem_arbiter`.

## Test plan
1. Hold `rst`=0 for 2 cycles with `cpu_req`=1 → all outputs 0, `state`=0, `mem_we` never high.
2. LATENCY=2; CPU read of `cpu_addr`=0x005, memory returns 0x8C010014 → `mem_addr`=0x005 in cycles 1–2; `cpu_ready`=1 and `cpu_rdata`=0x8C010014 in cycle 3; `dbg_ready` stays 0.
3. Debug write, `dbg_addr`=0x016, `dbg_wdata`=0x00000007 → `mem_we`=1 for exactly cycle 1 with `mem_wdata`=0x7; `dbg_ready` pulses in cycle 3; `dbg_rdata` unchanged.
4. Both `req` held high through two accesses → `owner` sequence is 0,0 without `ARB_RR_EN` and 0,1 with `ARB_RR_EN`; the second grant comes exactly 4 cycles after the first.
5. `rst`=0 during cycle 1 of a CPU read → `state`=0 next cycle, no `cpu_ready`; a following debug read completes normally in 3 cycles.
6. `cpu_req` dropped in cycle 1 → `cpu_ready` still pulses once in cycle 3; `state` stays IDLE afterwards.
